acq_trigger_ctrl: RTL and testbench

Acquisition trigger controller driving the active-high `rst` input of the BRAM address counter. It arms on a software request and waits for a rising edge on an external trigger. On that edge it releases the counter for exactly a programmed number of cycles, then holds it in reset and flags completion. Software reads `done` before fetching the captured samples.

---
 rtl/acq_ctrl_pkg.sv | 28 ++
 rtl/sync_edge_detect.sv | 34 +++
 rtl/acq_trigger_ctrl.sv | 126 ++++++++++++
 tb/tb_acq_trigger_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/acq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acq_ctrl_pkg
// Description : Shared state encoding and capture-length helper for the
//               acquisition trigger controller.
// Revision    : 1.0
// ============================================================================
package acq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } acq_state_t;

  // A zero request means a full-depth capture; oversized requests clamp to full depth.
  function automatic logic [31:0] eff_len(input logic [31:0] capture_len,
                                          input int          count_width);
    logic [31:0] max_len;
    max_len = 32'd1 << count_width;
    if ((capture_len == 32'd0) || (capture_len > max_len))
      return max_len;
    return capture_len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Multi-flop synchroniser with a registered rising-edge pulse.
// Revision    : 1.0
// ============================================================================
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_in,
  output logic trig_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  // The pulse is formed as the last stage loads, so it is high in exactly the
  // cycle where the final stage reads 1 and previously read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], trig_in};
      r_edge <= r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    end
  end

  assign trig_edge = r_edge;

endmodule
`default_nettype wire

// File: rtl/acq_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : acq_trigger_ctrl
// Description : Arms on request, waits for a trigger edge, then releases the
//               BRAM address counter for a programmed number of cycles.
// Revision    : 1.0
// ============================================================================
module acq_trigger_ctrl
  import acq_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig_in,
  input  logic [COUNT_WIDTH:0]   capture_len,
  output logic                   counter_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [COUNT_WIDTH:0]   samples_done,
  output logic [31:0]            trig_count
);

  localparam int LW = COUNT_WIDTH + 1;

  acq_state_t      r_state, w_state_nxt;
  logic [LW-1:0]   r_len_q, w_len_nxt;
  logic [LW-1:0]   r_samples, w_samples_nxt;
  logic [31:0]     r_trig_count, w_trig_count_nxt;
  logic            r_done, w_done_nxt;
  logic            r_overrun, w_overrun_nxt;
  logic            r_counter_rst;
  logic            r_busy;
  logic            w_trig_edge;
  logic [31:0]     w_eff_len;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig_in   (trig_in),
    .trig_edge (w_trig_edge)
  );

  assign w_eff_len = eff_len(32'(capture_len), COUNT_WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_len_q       <= '0;
      r_samples     <= '0;
      r_trig_count  <= '0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
      r_counter_rst <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_len_q       <= w_len_nxt;
      r_samples     <= w_samples_nxt;
      r_trig_count  <= w_trig_count_nxt;
      r_done        <= w_done_nxt;
      r_overrun     <= w_overrun_nxt;
      r_counter_rst <= (w_state_nxt != CAPTURE);
      r_busy        <= (w_state_nxt == ARMED) || (w_state_nxt == CAPTURE);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len_q;
    w_samples_nxt    = r_samples;
    w_trig_count_nxt = r_trig_count;
    w_done_nxt       = r_done;
    w_overrun_nxt    = r_overrun;
    case (r_state)
      IDLE, DONE: begin
        // A trigger edge coincident with arm is deliberately dropped here.
        if (arm) begin
          w_state_nxt   = ARMED;
          w_len_nxt     = w_eff_len[LW-1:0];
          w_samples_nxt = '0;
          w_done_nxt    = 1'b0;
          w_overrun_nxt = 1'b0;
        end
      end
      ARMED: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_trig_edge) begin
          w_state_nxt      = CAPTURE;
          w_trig_count_nxt = r_trig_count + 32'd1;
          w_samples_nxt    = '0;
        end
      end
      CAPTURE: begin
        if (w_trig_edge)
          w_overrun_nxt = 1'b1;
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_samples == (r_len_q - LW'(1))) begin
          w_state_nxt   = DONE;
          w_samples_nxt = r_len_q;
          w_done_nxt    = 1'b1;
        end else begin
          w_samples_nxt = r_samples + LW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign counter_rst  = r_counter_rst;
  assign busy         = r_busy;
  assign done         = r_done;
  assign overrun      = r_overrun;
  assign samples_done = r_samples;
  assign trig_count   = r_trig_count;

endmodule
`default_nettype wire

// File: tb/tb_acq_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_trigger_ctrl
// Description : Directed self-checking bench for acq_trigger_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_acq_trigger_ctrl;

  localparam int CW = 4;
  localparam int LW = CW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig_in = 1'b0;
  logic [LW-1:0] capture_len = '0;
  logic          counter_rst;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [LW-1:0] samples_done;
  logic [31:0]   trig_count;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int low;
  int k;

  acq_trigger_ctrl #(
    .COUNT_WIDTH (CW),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .abort        (abort),
    .trig_in      (trig_in),
    .capture_len  (capture_len),
    .counter_rst  (counter_rst),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .samples_done (samples_done),
    .trig_count   (trig_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves trig_in low long enough to flush the synchroniser, arms, then raises trig_in.
  task automatic start_acq(input logic [LW-1:0] len);
    trig_in = 1'b0;
    tick(4);
    capture_len = len;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    check_val("busy_after_arm", 32'(busy), 32'd1);
    check_val("done_clr_on_arm", 32'(done), 32'd0);
    trig_in = 1'b1;
  endtask

  // lat: edges until counter_rst falls; low: edges it stays low.
  // glitch>0 drops trig_in at capture start and re-raises it after glitch cycles.
  task automatic run_capture(input int glitch, output int lat_o, output int low_o);
    lat_o = 0;
    while (counter_rst && lat_o < 40) begin
      @(negedge clk);
      lat_o++;
    end
    low_o = 0;
    if (glitch > 0) trig_in = 1'b0;
    while (!counter_rst && low_o < 100) begin
      @(negedge clk);
      low_o++;
      if (low_o == glitch) trig_in = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tick(2);
    check_val("rst_counter_rst", 32'(counter_rst), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_samples", 32'(samples_done), 32'd0);
    check_val("rst_trig_count", trig_count, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Basic 5-sample capture
    start_acq(5'd5);
    run_capture(0, lat, low);
    check_val("t1_latency", lat, 3);
    check_val("t1_low_cycles", low, 5);
    check_val("t1_done", 32'(done), 32'd1);
    check_val("t1_samples", 32'(samples_done), 32'd5);
    check_val("t1_trig_count", trig_count, 32'd1);
    check_val("t1_busy", 32'(busy), 32'd0);

    // Zero and over-range lengths clamp to 16 (31 is the largest value the 5-bit port holds)
    start_acq(5'd0);
    run_capture(0, lat, low);
    check_val("t2_len0_low", low, 16);
    check_val("t2_len0_samples", 32'(samples_done), 32'd16);
    start_acq(5'd31);
    run_capture(0, lat, low);
    check_val("t2_len31_low", low, 16);
    start_acq(5'd17);
    run_capture(0, lat, low);
    check_val("t2_len17_low", low, 16);
    check_val("t2_trig_count", trig_count, 32'd4);

    // Second edge mid-capture
    start_acq(5'd10);
    run_capture(2, lat, low);
    check_val("t3_low_cycles", low, 10);
    check_val("t3_overrun", 32'(overrun), 32'd1);
    check_val("t3_trig_count", trig_count, 32'd5);
    check_val("t3_samples", 32'(samples_done), 32'd10);
    capture_len = 5'd3;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    check_val("t3_overrun_clr", 32'(overrun), 32'd0);
    check_val("t3_done_clr", 32'(done), 32'd0);
    check_val("t3_samples_clr", 32'(samples_done), 32'd0);

    // Abort from ARMED, then edges in IDLE and arm coincident with an edge
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_val("t4_abort_busy", 32'(busy), 32'd0);
    trig_in = 1'b0;
    tick(4);
    trig_in = 1'b1;
    tick(4);
    trig_in = 1'b0;
    tick(4);
    check_val("t4_idle_trig_count", trig_count, 32'd5);
    check_val("t4_idle_counter_rst", 32'(counter_rst), 32'd1);
    trig_in = 1'b1;
    tick(2);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(5);
    check_val("t4_coinc_busy", 32'(busy), 32'd1);
    check_val("t4_coinc_counter_rst", 32'(counter_rst), 32'd1);
    check_val("t4_coinc_trig_count", trig_count, 32'd5);
    trig_in = 1'b0;
    tick(4);
    trig_in = 1'b1;
    run_capture(0, lat, low);
    check_val("t4_fresh_latency", lat, 3);
    check_val("t4_fresh_low", low, 3);
    check_val("t4_fresh_trig_count", trig_count, 32'd6);

    // Abort 4 cycles into capture
    start_acq(5'd10);
    k = 0;
    while (counter_rst && k < 40) begin
      tick(1);
      k++;
    end
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_val("t5_counter_rst", 32'(counter_rst), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_done", 32'(done), 32'd0);
    check_val("t5_samples", 32'(samples_done), 32'd4);
    tick(3);
    check_val("t5_stays_idle", 32'(counter_rst), 32'd1);

    // Asynchronous reset between clock edges mid-capture
    start_acq(5'd8);
    k = 0;
    while (counter_rst && k < 40) begin
      tick(1);
      k++;
    end
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_async_counter_rst", 32'(counter_rst), 32'd1);
    check_val("t6_async_busy", 32'(busy), 32'd0);
    check_val("t6_async_samples", 32'(samples_done), 32'd0);
    check_val("t6_async_trig_count", trig_count, 32'd0);
    check_val("t6_async_done", 32'(done), 32'd0);
    check_val("t6_async_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_acq(5'd5);
    run_capture(0, lat, low);
    check_val("t6_post_latency", lat, 3);
    check_val("t6_post_low", low, 5);
    check_val("t6_post_done", 32'(done), 32'd1);
    check_val("t6_post_trig_count", trig_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
